// File: rtl/div_hilo_ctrl.sv
// EX-stage sequencer for signed DIV: latches operands, starts the divider,
// stalls the pipeline while it runs, and owns the HI/LO registers.
module div_hilo_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               div_req,
   input  logic [WIDTH-1:0]   div_dividend,
   input  logic [WIDTH-1:0]   div_divisor,
   input  logic               kill,
   input  logic               mt_hi,
   input  logic               mt_lo,
   input  logic [WIDTH-1:0]   mt_data,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               stall,
   output logic               dz,
   output logic [2*WIDTH-1:0] dv_a,
   output logic [WIDTH-1:0]   dv_b,
   output logic               dv_start,
   input  logic               dv_busy,
   input  logic [2*WIDTH-1:0] dv_q,
   input  logic [WIDTH-1:0]   dv_r
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] op_a_r;
   logic [WIDTH-1:0] op_b_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             dz_r;
   logic             dv_start_r;
   logic             started_r;
   logic             stall_s;
   logic             idle_s;
   logic             div_zero_s;
   logic             accept_s;
   logic             dz_bypass_s;
   logic             mt_ok_s;
   logic             capture_s;
   logic             unused_q_hi_s;

   assign idle_s      = (state_r == ST_IDLE);
   assign div_zero_s  = (div_divisor == {WIDTH{1'b0}});
   assign accept_s    = idle_s & div_req & ~kill & ~div_zero_s;
   assign dz_bypass_s = idle_s & div_req & ~kill & div_zero_s;
   // Any DIV presented in IDLE (including the zero-divisor bypass) wins over MTHI/MTLO.
   assign mt_ok_s     = idle_s & ~kill & ~div_req;
   assign capture_s   = (state_r == ST_WAIT_LO) & ~kill & ~dv_busy;
   assign unused_q_hi_s = ^dv_q[2*WIDTH-1:WIDTH];

   // Next-state and combinational stall decode.
   always_comb begin
      state_s = state_r;
      stall_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stall_s = accept_s;
            if (accept_s) state_s = ST_ISSUE;
            else          state_s = ST_IDLE;
         end
         ST_ISSUE: begin
            stall_s = 1'b1;
            if (kill) state_s = ST_DRAIN;
            else      state_s = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            stall_s = 1'b1;
            if (kill)         state_s = ST_DRAIN;
            else if (dv_busy) state_s = ST_WAIT_LO;
            else              state_s = ST_WAIT_HI;
         end
         ST_WAIT_LO: begin
            stall_s = dv_busy;
            if (kill)          state_s = ST_DRAIN;
            else if (!dv_busy) state_s = ST_IDLE;
            else               state_s = ST_WAIT_LO;
         end
         ST_DRAIN: begin
            stall_s = 1'b1;
            if (started_r && !dv_busy) state_s = ST_IDLE;
            else                       state_s = ST_DRAIN;
         end
         default: begin
            stall_s = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register, start pulse and the start-seen flag used by DRAIN.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         dv_start_r <= 1'b0;
         started_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         dv_start_r <= (state_s == ST_ISSUE);
         if (state_s == ST_IDLE) started_r <= 1'b0;
         else if (dv_start_r)    started_r <= 1'b1;
         else                    started_r <= started_r;
      end
   end

   // Operand latch; held from ISSUE through capture so dv_a's sign bit stays stable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_a_r <= {WIDTH{1'b0}};
         op_b_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         op_a_r <= div_dividend;
         op_b_r <= div_divisor;
      end
   end

   // HI/LO and sticky divide-by-zero flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
         dz_r <= 1'b0;
      end else if (dz_bypass_s) begin
         hi_r <= div_dividend;
         lo_r <= {WIDTH{1'b1}};
         dz_r <= 1'b1;
      end else if (accept_s) begin
         dz_r <= 1'b0;
      end else if (capture_s) begin
         lo_r <= dv_q[WIDTH-1:0];
         hi_r <= dv_r;
      end else if (mt_ok_s) begin
         if (mt_hi) hi_r <= mt_data;
         if (mt_lo) lo_r <= mt_data;
      end
   end

   assign hi       = hi_r;
   assign lo       = lo_r;
   assign dz       = dz_r;
   assign stall    = stall_s;
   assign dv_start = dv_start_r;
   assign dv_a     = {{WIDTH{op_a_r[WIDTH-1]}}, op_a_r};
   assign dv_b     = op_b_r;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl with a behavioural 2*WIDTH-cycle divider model.
module tb_div_hilo_ctrl;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           div_req = 1'b0;
   logic [W-1:0]   div_dividend = '0;
   logic [W-1:0]   div_divisor = '0;
   logic           kill = 1'b0;
   logic           mt_hi = 1'b0;
   logic           mt_lo = 1'b0;
   logic [W-1:0]   mt_data = '0;
   logic [W-1:0]   hi, lo;
   logic           stall, dz;
   logic [2*W-1:0] dv_a;
   logic [W-1:0]   dv_b;
   logic           dv_start;
   logic           dv_busy;
   logic [2*W-1:0] dv_q;
   logic [W-1:0]   dv_r;

   div_hilo_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .div_req(div_req),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .kill(kill), .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
      .hi(hi), .lo(lo), .stall(stall), .dz(dz),
      .dv_a(dv_a), .dv_b(dv_b), .dv_start(dv_start),
      .dv_busy(dv_busy), .dv_q(dv_q), .dv_r(dv_r)
   );

   always #5 clk = ~clk;

   // Divider model: busy for 2*W cycles starting the cycle after dv_start.
   int busy_cnt;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_cnt <= 0;
         dv_q <= '0;
         dv_r <= '0;
      end else if (dv_start) begin
         longint sa, sb;
         sa = dv_a;
         sb = {{W{dv_b[W-1]}}, dv_b};
         busy_cnt <= 2*W;
         dv_q <= sa / sb;
         dv_r <= W'(sa % sb);
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign dv_busy = (busy_cnt != 0);

   int n_tests = 0;
   int n_fail = 0;
   int start_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;
   exp_t sb_q[$];

   task automatic push(input string name, input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
      exp_t e;
      e.name = name; e.hi = h; e.lo = l; e.dz = d;
      sb_q.push_back(e);
   endtask

   // Monitor: a retiring instruction's result is compared one cycle after it retires.
   bit   pend = 1'b0;
   exp_t e_m;
   always @(negedge clk) begin
      if (dv_start) start_cnt++;
      if (pend) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_retire: hi=0x%0h lo=0x%0h with no expectation queued", hi, lo);
         end else begin
            e_m = sb_q.pop_front();
            chk({e_m.name, "_hi"}, 64'(hi), 64'(e_m.hi));
            chk({e_m.name, "_lo"}, 64'(lo), 64'(e_m.lo));
            chk({e_m.name, "_dz"}, 64'(dz), 64'(e_m.dz));
         end
      end
      pend = resetn && !kill && !stall && (div_req || mt_hi || mt_lo);
   end

   task automatic drive(input logic req, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic k, input logic mh, input logic ml, input logic [W-1:0] md);
      @(posedge clk);
      #1;
      div_req = req; div_dividend = a; div_divisor = b;
      kill = k; mt_hi = mh; mt_lo = ml; mt_data = md;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Counts stalled cycles (accept cycle included) until the instruction retires.
   task automatic wait_retire(input string name, output int stalled);
      bit done = 1'b0;
      stalled = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stalled++;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: stall still 1 after 300 cycles, required 0", name);
      end
   endtask

   initial begin
      int st, s0, j;
      bit seen;

      repeat (3) @(negedge clk);
      chk("rst_hi", 64'(hi), 64'h0);
      chk("rst_lo", 64'(lo), 64'h0);
      chk("rst_dz", 64'(dz), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_start", 64'(dv_start), 64'h0);
      @(posedge clk); #1 resetn = 1'b1;

      // 100/7: one start pulse, stall high for 65 cycles after the accept cycle.
      s0 = start_cnt;
      push("t1_100_7", 32'd2, 32'd14, 1'b0);
      drive(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t1", st);
      chk("t1_stall_cycles", 64'(st - 1), 64'd65);
      chk("t1_start_pulses", 64'(start_cnt - s0), 64'd1);

      // Signed operand combinations, back-to-back.
      push("t2_m100_7", 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
      drive(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t2a", st);
      push("t2_100_m7", 32'd2, 32'hFFFFFFF2, 1'b0);
      drive(1'b1, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t2b", st);

      // Divide by zero bypass, then a normal DIV clears dz.
      s0 = start_cnt;
      push("t3_5_0", 32'd5, 32'hFFFFFFFF, 1'b1);
      drive(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t3a", st);
      chk("t3_dz_stall_cycles", 64'(st), 64'd0);
      idle();
      @(negedge clk);
      chk("t3_dz_no_start", 64'(start_cnt - s0), 64'd0);
      push("t3_9_3", 32'd0, 32'd3, 1'b0);
      drive(1'b1, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t3b", st);

      // MTHI in IDLE; MTLO colliding with an accepted DIV is dropped.
      push("t5_mthi", 32'h1234, 32'd3, 1'b0);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1234);
      wait_retire("t5a", st);
      push("t5_mtlo_div", 32'd0, 32'd5, 1'b0);
      drive(1'b1, 32'd20, 32'd4, 1'b0, 1'b0, 1'b1, 32'hDEAD);
      wait_retire("t5b", st);
      push("t5_mt_aa", 32'hAA, 32'hAA, 1'b0);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hAA);
      wait_retire("t5c", st);

      // Kill at cycle 10 of 100/7, then 9/2 re-requested immediately.
      drive(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (10) @(negedge clk);
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      chk("t4_kill_stall", 64'(stall), 64'h1);
      push("t4_9_2", 32'd1, 32'd4, 1'b0);
      @(posedge clk); #1;
      kill = 1'b0; div_req = 1'b1; div_dividend = 32'd9; div_divisor = 32'd2;
      j = 11;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (dv_start) begin
            seen = 1'b1;
            break;
         end
         j++;
      end
      chk("t4_restart_seen", 64'(seen), 64'h1);
      chk("t4_restart_cycle", 64'(j), 64'd68);
      chk("t4_hi_kept", 64'(hi), 64'hAA);
      chk("t4_lo_kept", 64'(lo), 64'hAA);
      wait_retire("t4", st);

      // Reset in the middle of WAIT_LO.
      drive(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      resetn = 1'b0; div_req = 1'b0;
      #1;
      chk("t6_rst_hi", 64'(hi), 64'h0);
      chk("t6_rst_lo", 64'(lo), 64'h0);
      chk("t6_rst_stall", 64'(stall), 64'h0);
      chk("t6_rst_state", 64'(dut.state_r), 64'h0);
      @(posedge clk); #1 resetn = 1'b1;

      // Overflow case: low half of the 2W quotient.
      push("t6_ovf", 32'd0, 32'h80000000, 1'b0);
      drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_retire("t6", st);
      idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
